demux_1to4_reg: RTL

//  Registered 1-to-4 demultiplexer: routes one 64-bit word per cycle from a

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_slot.sv | 47 ++++
 rtl/demux_1to4_reg.sv | 68 ++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Slot state is a single bit, so EMPTY/FULL are plain localparams.
package demux_pkg;
  localparam int   NUM_OUT       = 4;
  localparam int   SEL_W         = 2;
  localparam int   DEFAULT_WIDTH = 64;
  localparam logic EMPTY         = 1'b0;
  localparam logic FULL          = 1'b1;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single sink. The parent only asserts load
// when the slot is EMPTY or is being drained in the same cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // NOTE: assign every output a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (state_q == FULL && ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the data
  // register is reset too because the lane must read zero after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign full = state_q;
  assign data = data_q;

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 valid/ready demultiplexer with per-sink holding slots.
// Define DEMUX_BROADCAST_EN to add in_bcast, which loads a word into all slots.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [WIDTH-1:0]         in_data,
`ifdef DEMUX_BROADCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data
);

  logic [NUM_OUT-1:0] slot_full;
  logic [NUM_OUT-1:0] load;
  logic               bcast;
  logic               uni_ok;
  logic               all_ok;
  logic               accept;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A slot can take a word if it is empty or its old word leaves this cycle.
  always_comb begin
    uni_ok = (slot_full[in_sel] == EMPTY) || out_ready[in_sel];
    all_ok = 1'b1;
    for (int i = 0; i < NUM_OUT; i++) begin
      all_ok = all_ok && ((slot_full[i] == EMPTY) || out_ready[i]);
    end
    in_ready = !reset && (bcast ? all_ok : uni_ok);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      load[i] = accept && (bcast || (in_sel == SEL_W'(i)));
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .load      (load[g]),
      .load_data (in_data),
      .ready     (out_ready[g]),
      .full      (slot_full[g]),
      .data      (out_data[g*WIDTH +: WIDTH])
    );
  end

  assign out_valid = slot_full;

endmodule
